// File: rtl/tpu_mmio_bridge.sv
// In-order MMIO request sequencer in front of the TPU core's single-cycle r_w/addr/dataIn port.
// Optional macro TPU_BRIDGE_ADDR_CHECK_EN enables the address map filter and the sticky err flag.
module tpu_mmio_bridge #(
    parameter int DIM   = 8,
    parameter int ADDRW = 16,
    parameter int DATAW = 64,
    parameter int TIDW  = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [ADDRW-1:0] req_addr,
    input  logic [DATAW-1:0] req_data,
    input  logic [TIDW-1:0]  req_tid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DATAW-1:0] rsp_data,
    output logic [TIDW-1:0]  rsp_tid,
    output logic             tpu_r_w,
    output logic [ADDRW-1:0] tpu_addr,
    output logic [DATAW-1:0] tpu_data_in,
    input  logic [DATAW-1:0] tpu_data_out,
    output logic             busy,
    output logic             err
);

    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(3 * DIM);
    localparam logic [ADDRW-1:0] MATMUL_ADDR = ADDRW'('h0400);

    typedef struct packed {
        logic             wr;
        logic [ADDRW-1:0] addr;
        logic [DATAW-1:0] data;
        logic [TIDW-1:0]  tid;
    } req_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        MUL_WAIT,
        RSP_HOLD
    } state_t;

    req_t             mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, rd_ptr_q;
    req_t             iss_q;
    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [DATAW-1:0] rsp_data_q, rsp_data_d;
    logic [TIDW-1:0]  rsp_tid_q, rsp_tid_d;
    logic             busy_q;
    logic             empty, full, push, pop, addr_ok;

    // Extra wrap bit on each pointer distinguishes full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign push  = req_valid && !full;
    assign pop   = (state_q == IDLE) && !empty;

    assign req_ready = !full;

    // NOTE: storage array carries no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= '{wr: req_wr, addr: req_addr, data: req_data, tid: req_tid};
        end
    end

    // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            iss_q       <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tid_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            if (pop) begin
                iss_q    <= mem_q[rd_ptr_q[PW-1:0]];
                rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
            end
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tid_q   <= rsp_tid_d;
            busy_q      <= (state_d == MUL_WAIT);
        end
    end

`ifdef TPU_BRIDGE_ADDR_CHECK_EN
    logic err_q;

    assign addr_ok = ((req_addr_in_range(iss_q.addr)) || (iss_q.addr == MATMUL_ADDR));

    function automatic logic req_addr_in_range(input logic [ADDRW-1:0] a);
        return (a >= ADDRW'('h0100)) && (a <= ADDRW'('h03FF));
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (state_q == ISSUE && !addr_ok) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign addr_ok = 1'b1;
    assign err     = 1'b0;
`endif

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_tid_d   = rsp_tid_q;
        case (state_q)
            IDLE: begin
                if (!empty) state_d = ISSUE;
            end
            ISSUE: begin
                if (iss_q.wr) begin
                    if (addr_ok && iss_q.addr == MATMUL_ADDR) begin
                        state_d = MUL_WAIT;
                        cnt_d   = CNTW'(3 * DIM - 2);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = addr_ok ? tpu_data_out : '0;
                    rsp_tid_d   = iss_q.tid;
                    state_d     = RSP_HOLD;
                end
            end
            MUL_WAIT: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNTW'(1);
            end
            RSP_HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Core port is kept in its own process: tpu_data_out depends combinationally on tpu_addr.
    always_comb begin
        tpu_r_w     = 1'b0;
        tpu_addr    = '0;
        tpu_data_in = '0;
        if (state_q == ISSUE && addr_ok) begin
            tpu_r_w     = iss_q.wr;
            tpu_addr    = iss_q.addr;
            tpu_data_in = iss_q.wr ? iss_q.data : '0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_tid   = rsp_tid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_tpu_mmio_bridge.sv
// Directed self-checking bench for tpu_mmio_bridge; a passive monitor logs every core strobe.
module tb_tpu_mmio_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wr;
    logic [15:0] req_addr;
    logic [63:0] req_data;
    logic [8:0]  req_tid;
    logic        rsp_valid, rsp_ready;
    logic [63:0] rsp_data;
    logic [8:0]  rsp_tid;
    logic        tpu_r_w;
    logic [15:0] tpu_addr;
    logic [63:0] tpu_data_in, tpu_data_out;
    logic        busy, err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] log_addr [$];
    logic        log_wr   [$];
    logic [63:0] log_din  [$];
    int          log_cyc  [$];
    int          busy_cnt   = 0;
    int          busy_first = 0;
    logic        busy_prev  = 1'b0;

    // Core model: dataOut is a fixed tag concatenated with the address.
    assign tpu_data_out = {16'hC0DE, 32'h0, tpu_addr};

    tpu_mmio_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_data(req_data), .req_tid(req_tid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tid(rsp_tid),
        .tpu_r_w(tpu_r_w), .tpu_addr(tpu_addr), .tpu_data_in(tpu_data_in),
        .tpu_data_out(tpu_data_out), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tpu_r_w || tpu_addr != 16'h0 || tpu_data_in != 64'h0) begin
            log_addr.push_back(tpu_addr);
            log_wr.push_back(tpu_r_w);
            log_din.push_back(tpu_data_in);
            log_cyc.push_back(cyc);
        end
        if (busy) begin
            if (!busy_prev) busy_first <= cyc;
            busy_cnt <= busy_cnt + 1;
        end
        busy_prev <= busy;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves req_valid high so consecutive calls form a back-to-back burst.
    task automatic push(input logic wr, input logic [15:0] a, input logic [63:0] d, input logic [8:0] t);
        int n;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_data  = d;
        req_tid   = t;
        n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        if (!req_ready) check("push_timeout", 64'(req_ready), 64'd1);
        step();
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (!rsp_valid && n < 80) begin
            step();
            n++;
        end
        check(tag, 64'(rsp_valid), 64'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req_ready"},   64'(req_ready),   64'd1);
        check({pfx, "_rsp_valid"},   64'(rsp_valid),   64'd0);
        check({pfx, "_rsp_data"},    rsp_data,         64'd0);
        check({pfx, "_rsp_tid"},     64'(rsp_tid),     64'd0);
        check({pfx, "_tpu_r_w"},     64'(tpu_r_w),     64'd0);
        check({pfx, "_tpu_addr"},    64'(tpu_addr),    64'd0);
        check({pfx, "_tpu_data_in"}, tpu_data_in,      64'd0);
        check({pfx, "_busy"},        64'(busy),        64'd0);
        check({pfx, "_err"},         64'(err),         64'd0);
    endtask

    initial begin
        int base, nb;
        int n;

        rst_n = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_data = '0; req_tid = '0;
        rsp_ready = 1'b1;
        #3 rst_n = 1'b0;
        #1 check_reset_outputs("rst");
        step(2);
        rst_n = 1'b1;
        step(2);

        // Write burst: registered pop, one issue every 2 cycles, parked in between.
        base = log_addr.size();
        for (int k = 0; k < 8; k++) begin
            push(1'b1, 16'h0100 + 16'(8 * k), 64'h0807060504030201 + 64'(k), 9'(k));
            if (k == 0) check("burst_no_bypass", 64'(tpu_addr), 64'h0);
        end
        req_valid = 1'b0;
        step(20);
        check("burst_count", 64'(log_addr.size() - base), 64'd8);
        if (log_addr.size() >= base + 8) begin
            for (int k = 0; k < 8; k++) begin
                check($sformatf("burst_addr%0d", k), 64'(log_addr[base+k]), 64'h0100 + 64'(8 * k));
                check($sformatf("burst_din%0d", k), log_din[base+k], 64'h0807060504030201 + 64'(k));
                if (k > 0) check($sformatf("burst_gap%0d", k), 64'(log_cyc[base+k] - log_cyc[base+k-1]), 64'd2);
            end
        end

        // MatMul stall: busy 23 cycles, queued read issues 25 cycles after the MatMul issue.
        base = log_addr.size();
        nb   = busy_cnt;
        push(1'b1, 16'h0400, 64'h1, 9'h010);
        push(1'b0, 16'h0300, 64'hDEAD, 9'h011);
        req_valid = 1'b0;
        wait_rsp("mm_rsp_seen");
        check("mm_rsp_data", rsp_data, 64'hC0DE_0000_0000_0300);
        check("mm_rsp_tid", 64'(rsp_tid), 64'h011);
        step(2);
        check("mm_busy_cycles", 64'(busy_cnt - nb), 64'd23);
        check("mm_count", 64'(log_addr.size() - base), 64'd2);
        if (log_addr.size() >= base + 2) begin
            check("mm_addr", 64'(log_addr[base]), 64'h0400);
            check("mm_busy_start", 64'(busy_first - log_cyc[base]), 64'd1);
            check("mm_rd_addr", 64'(log_addr[base+1]), 64'h0300);
            check("mm_rd_r_w", 64'(log_wr[base+1]), 64'd0);
            check("mm_rd_din", log_din[base+1], 64'h0);
            check("mm_rd_delay", 64'(log_cyc[base+1] - log_cyc[base]), 64'd25);
        end

        // Read backpressure: response held stable, nothing issued until handshake.
        rsp_ready = 1'b0;
        base = log_addr.size();
        push(1'b0, 16'h0308, 64'h0, 9'h1A5);
        push(1'b1, 16'h0280, 64'h55, 9'h002);
        req_valid = 1'b0;
        wait_rsp("bp_rsp_seen");
        nb = log_addr.size();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid%0d", i), 64'(rsp_valid), 64'd1);
            check($sformatf("bp_data%0d", i), rsp_data, 64'hC0DE_0000_0000_0308);
            check($sformatf("bp_tid%0d", i), 64'(rsp_tid), 64'h1A5);
            step();
        end
        check("bp_no_issue", 64'(log_addr.size() - base), 64'd1);
        rsp_ready = 1'b1;
        step();
        check("bp_release", 64'(rsp_valid), 64'd0);
        step(6);
        check("bp_next_count", 64'(log_addr.size() - nb), 64'd1);
        if (log_addr.size() > nb) check("bp_next_addr", 64'(log_addr[nb]), 64'h0280);

        // FIFO full: eight queued writes behind a stalled read, ninth waits for space.
        rsp_ready = 1'b0;
        push(1'b0, 16'h0310, 64'h0, 9'h020);
        req_valid = 1'b0;
        wait_rsp("full_rsp_seen");
        check("full_rsp_data", rsp_data, 64'hC0DE_0000_0000_0310);
        base = log_addr.size();
        for (int k = 0; k < 8; k++) push(1'b1, 16'h0200 + 16'(8 * k), 64'h100 + 64'(k), 9'(k));
        check("full_ready_low", 64'(req_ready), 64'd0);
        req_wr = 1'b1; req_addr = 16'h0240; req_data = 64'h108; req_tid = 9'h008;
        step(3);
        check("full_ready_held", 64'(req_ready), 64'd0);
        check("full_no_issue", 64'(log_addr.size() - base), 64'd0);
        rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            step();
            n++;
        end
        check("full_ready_back", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        step(30);
        check("full_count", 64'(log_addr.size() - base), 64'd9);
        if (log_addr.size() >= base + 9) begin
            for (int k = 0; k < 9; k++) begin
                check($sformatf("full_addr%0d", k), 64'(log_addr[base+k]), 64'h0200 + 64'(8 * k));
                check($sformatf("full_din%0d", k), log_din[base+k], 64'h100 + 64'(k));
            end
        end

        // Unmapped address 0x0500.
        base = log_addr.size();
        push(1'b0, 16'h0500, 64'h0, 9'h0AB);
        req_valid = 1'b0;
        wait_rsp("unm_rsp_seen");
        check("unm_tid", 64'(rsp_tid), 64'h0AB);
`ifdef TPU_BRIDGE_ADDR_CHECK_EN
        check("unm_data", rsp_data, 64'h0);
        step(4);
        check("unm_err", 64'(err), 64'd1);
        check("unm_parked", 64'(log_addr.size() - base), 64'd0);
        push(1'b1, 16'h0108, 64'h77, 9'h003);
        req_valid = 1'b0;
        step(4);
        check("unm_err_sticky", 64'(err), 64'd1);
        check("unm_next_count", 64'(log_addr.size() - base), 64'd1);
        if (log_addr.size() > base) check("unm_next_addr", 64'(log_addr[base]), 64'h0108);
`else
        check("unm_data", rsp_data, 64'hC0DE_0000_0000_0500);
        step(4);
        check("unm_err", 64'(err), 64'd0);
        check("unm_count", 64'(log_addr.size() - base), 64'd1);
        if (log_addr.size() > base) check("unm_addr", 64'(log_addr[base]), 64'h0500);
`endif

        // Reset mid-operation: held response plus queued writes are discarded.
        rsp_ready = 1'b0;
        push(1'b0, 16'h0318, 64'h0, 9'h033);
        for (int k = 0; k < 3; k++) push(1'b1, 16'h0120 + 16'(8 * k), 64'h9 + 64'(k), 9'(k));
        req_valid = 1'b0;
        wait_rsp("mrst_rsp_seen");
        base = log_addr.size();
        rst_n = 1'b0;
        #1 check_reset_outputs("mrst");
        step(2);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        step(10);
        check("mrst_lost", 64'(log_addr.size() - base), 64'd0);
        push(1'b1, 16'h0130, 64'hAA, 9'h004);
        req_valid = 1'b0;
        step(4);
        check("mrst_after_count", 64'(log_addr.size() - base), 64'd1);
        if (log_addr.size() > base) check("mrst_after_addr", 64'(log_addr[base]), 64'h0130);

        // Reset during the MatMul window clears busy at once.
        push(1'b1, 16'h0400, 64'h2, 9'h005);
        req_valid = 1'b0;
        step(5);
        check("mmrst_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1 check("mmrst_busy_cleared", 64'(busy), 64'd0);
        step();
        rst_n = 1'b1;
        step(2);
        check("mmrst_busy_after", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
